// File: rtl/sram_image_pkg.sv
// Shared types and sizing helpers for the SRAM image controller.
package sram_image_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StFlush,
    StRdAddr,
    StRdWait,
    StRdOut,
    StDone
  } state_e;

  function automatic int unsigned pixels_per_word(input int unsigned word_w,
                                                  input int unsigned pixel_w);
    return word_w / pixel_w;
  endfunction

  // Width of an index over n items; never narrower than one bit.
  function automatic int unsigned slot_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_word_packer.sv
// Word register with slot counter: packs pixels for writes, unpacks loaded words for reads.
// Slot 0 is the least significant pixel unless SRAM_IMG_MSB_FIRST_EN is defined.
module pixel_word_packer
  import sram_image_pkg::*;
#(
  parameter int unsigned PIXEL_W = 2,
  parameter int unsigned WORD_W  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic               i_load,
  input  logic               i_advance,
  input  logic [PIXEL_W-1:0] i_pixel,
  input  logic [WORD_W-1:0]  i_word,
  output logic [WORD_W-1:0]  o_merged,
  output logic [PIXEL_W-1:0] o_pixel,
  output logic               o_last
);

  localparam int unsigned PPW    = pixels_per_word(WORD_W, PIXEL_W);
  localparam int unsigned SLOT_W = slot_width(PPW);
  localparam int unsigned POS_W  = slot_width(WORD_W);

  logic [WORD_W-1:0]  r_word;
  logic [SLOT_W-1:0]  r_slot;
  logic [POS_W-1:0]   w_pos;
  logic [WORD_W-1:0]  w_merged;

  always_comb begin
`ifdef SRAM_IMG_MSB_FIRST_EN
    w_pos = POS_W'(WORD_W - PIXEL_W) - POS_W'(r_slot) * POS_W'(PIXEL_W);
`else
    w_pos = POS_W'(r_slot) * POS_W'(PIXEL_W);
`endif
  end

  // Current word with the incoming pixel dropped into the active slot.
  always_comb begin
    w_merged = r_word;
    w_merged[w_pos +: PIXEL_W] = i_pixel;
  end

  assign o_merged = w_merged;
  assign o_pixel  = r_word[w_pos +: PIXEL_W];
  assign o_last   = (r_slot == SLOT_W'(PPW - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word <= '0;
      r_slot <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_slot <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_slot <= '0;
    end else if (i_push) begin
      if (o_last) begin
        r_word <= '0;
        r_slot <= '0;
      end else begin
        r_word <= w_merged;
        r_slot <= r_slot + SLOT_W'(1);
      end
    end else if (i_advance) begin
      r_slot <= o_last ? '0 : r_slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/sram_image_ctrl.sv
// Transfers an image between a pixel stream and a word-wide synchronous SRAM, in either direction.
// Slot order follows pixel_word_packer (SRAM_IMG_MSB_FIRST_EN selects MSB-first packing).
module sram_image_ctrl
  import sram_image_pkg::*;
#(
  parameter int unsigned PIXEL_W = 2,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned SIZE_W  = 23
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SIZE_W-1:0]  image_size,
  input  logic [ADDR_W-1:0]  image_start_addr,
  input  logic               write_image_en,
  input  logic               write_image,
  input  logic [PIXEL_W-1:0] write_image_data,
  output logic               write_image_done,
  input  logic               read_image_en,
  output logic               read_image,
  input  logic               read_image_ready,
  output logic [PIXEL_W-1:0] read_image_data,
  output logic               read_image_done,
  output logic               sram_clock,
  output logic               sram_write,
  output logic [WORD_W-1:0]  sram_write_data,
  output logic [ADDR_W-1:0]  sram_write_addr,
  input  logic [WORD_W-1:0]  sram_read_data,
  output logic [ADDR_W-1:0]  sram_read_addr
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_is_read;
  logic [SIZE_W-1:0]  r_size;
  logic [SIZE_W-1:0]  r_pix_cnt;
  logic [SIZE_W-1:0]  w_pix_cnt_inc;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic               r_sram_write;
  logic [WORD_W-1:0]  r_sram_write_data;
  logic [ADDR_W-1:0]  r_sram_write_addr;
  logic [ADDR_W-1:0]  r_sram_read_addr;

  logic               w_leave_idle;
  logic               w_final;
  logic               w_accept;
  logic               w_xfer;
  logic               w_pk_clear;
  logic               w_pk_load;
  logic [WORD_W-1:0]  w_pk_merged;
  logic [PIXEL_W-1:0] w_pk_pixel;
  logic               w_pk_last;

  assign w_pix_cnt_inc = r_pix_cnt + SIZE_W'(1);
  assign w_final       = (w_pix_cnt_inc == r_size);
  assign w_leave_idle  = (r_state == StIdle) && (w_state_next != StIdle);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_xfer       = 1'b0;
    w_pk_clear   = 1'b0;
    w_pk_load    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_pk_clear = 1'b1;
        if (write_image_en) begin
          w_state_next = (image_size == '0) ? StDone : StWrite;
        end else if (read_image_en) begin
          w_state_next = (image_size == '0) ? StDone : StRdAddr;
        end
      end
      StWrite: begin
        if (!write_image_en) begin
          w_state_next = StIdle;
        end else if (write_image) begin
          w_accept = 1'b1;
          if (w_final) w_state_next = StFlush;
        end
      end
      // The final word is on the SRAM port during this state.
      StFlush: begin
        w_state_next = write_image_en ? StDone : StIdle;
      end
      StRdAddr: begin
        w_state_next = read_image_en ? StRdWait : StIdle;
      end
      StRdWait: begin
        if (!read_image_en) begin
          w_state_next = StIdle;
        end else begin
          w_pk_load    = 1'b1;
          w_state_next = StRdOut;
        end
      end
      StRdOut: begin
        if (!read_image_en) begin
          w_state_next = StIdle;
        end else if (read_image_ready) begin
          w_xfer = 1'b1;
          if (w_final) begin
            w_state_next = StDone;
          end else if (w_pk_last) begin
            w_state_next = StRdAddr;
          end
        end
      end
      StDone: begin
        if (!(r_is_read ? read_image_en : write_image_en)) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_is_read         <= 1'b0;
      r_size            <= '0;
      r_pix_cnt         <= '0;
      r_wr_addr         <= '0;
      r_sram_write      <= 1'b0;
      r_sram_write_data <= '0;
      r_sram_write_addr <= '0;
      r_sram_read_addr  <= '0;
    end else begin
      r_sram_write <= 1'b0;
      if (w_leave_idle) begin
        r_is_read        <= !write_image_en;
        r_size           <= image_size;
        r_pix_cnt        <= '0;
        r_wr_addr        <= image_start_addr;
        r_sram_read_addr <= image_start_addr;
      end
      if (w_accept) begin
        r_pix_cnt <= w_pix_cnt_inc;
        // A full word, or the zero-padded tail of the image, goes out next cycle.
        if (w_pk_last || w_final) begin
          r_sram_write      <= 1'b1;
          r_sram_write_data <= w_pk_merged;
          r_sram_write_addr <= r_wr_addr;
          r_wr_addr         <= r_wr_addr + ADDR_W'(1);
        end
      end
      if (w_xfer) begin
        r_pix_cnt <= w_pix_cnt_inc;
        if (w_pk_last && !w_final) r_sram_read_addr <= r_sram_read_addr + ADDR_W'(1);
      end
    end
  end

  pixel_word_packer #(
    .PIXEL_W (PIXEL_W),
    .WORD_W  (WORD_W)
  ) u_packer (
    .i_clk     (clock),
    .i_reset   (reset),
    .i_clear   (w_pk_clear),
    .i_push    (w_accept),
    .i_load    (w_pk_load),
    .i_advance (w_xfer),
    .i_pixel   (write_image_data),
    .i_word    (sram_read_data),
    .o_merged  (w_pk_merged),
    .o_pixel   (w_pk_pixel),
    .o_last    (w_pk_last)
  );

  assign sram_clock       = clock;
  assign sram_write       = r_sram_write;
  assign sram_write_data  = r_sram_write_data;
  assign sram_write_addr  = r_sram_write_addr;
  assign sram_read_addr   = r_sram_read_addr;
  assign read_image       = (r_state == StRdOut);
  assign read_image_data  = w_pk_pixel;
  assign write_image_done = (r_state == StDone) && !r_is_read;
  assign read_image_done  = (r_state == StDone) && r_is_read;

endmodule

// File: tb/tb_sram_image_ctrl.sv
// Scoreboard bench for sram_image_ctrl: expected SRAM writes and read pixels are queued by the
// stimulus and consumed by a negedge monitor.
module tb_sram_image_ctrl;

  localparam int PPW = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [22:0] image_size;
  logic [12:0] image_start_addr;
  logic        write_image_en, write_image;
  logic [1:0]  write_image_data;
  logic        write_image_done;
  logic        read_image_en, read_image, read_image_ready;
  logic [1:0]  read_image_data;
  logic        read_image_done;
  logic        sram_clock, sram_write;
  logic [31:0] sram_write_data;
  logic [12:0] sram_write_addr, sram_read_addr;
  logic [31:0] sram_read_data;

  sram_image_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .image_size       (image_size),
    .image_start_addr (image_start_addr),
    .write_image_en   (write_image_en),
    .write_image      (write_image),
    .write_image_data (write_image_data),
    .write_image_done (write_image_done),
    .read_image_en    (read_image_en),
    .read_image       (read_image),
    .read_image_ready (read_image_ready),
    .read_image_data  (read_image_data),
    .read_image_done  (read_image_done),
    .sram_clock       (sram_clock),
    .sram_write       (sram_write),
    .sram_write_data  (sram_write_data),
    .sram_write_addr  (sram_write_addr),
    .sram_read_data   (sram_read_data),
    .sram_read_addr   (sram_read_addr)
  );

  always #5 clock = ~clock;

  // Synchronous SRAM for the read side: data valid the cycle after the address.
  logic [31:0] mem [8192];
  logic [31:0] rd_q;
  always @(posedge clock) rd_q <= mem[sram_read_addr];
  assign sram_read_data = rd_q;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [1:0] exp_px_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr_cyc = -10;
  int n_rd = 0;
  logic       stall_prev = 1'b0;
  logic [1:0] prev_data;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Bit position of a pixel slot inside a word.
  function automatic int unsigned slot_lsb(input int k);
`ifdef SRAM_IMG_MSB_FIRST_EN
    return 30 - 2 * k;
`else
    return 2 * k;
`endif
  endfunction

  always @(negedge clock) begin
    wr_t e;
    logic [1:0] p;
    if (sram_write === 1'b1) begin
      if (exp_wr_q.size() == 0) unexpected("sram_write");
      else begin
        e = exp_wr_q.pop_front();
        check("sram_write_addr", 64'(sram_write_addr), 64'(e.addr));
        check("sram_write_data", 64'(sram_write_data), 64'(e.data));
      end
      last_wr_cyc = cyc;
    end
    if (read_image === 1'b1 && stall_prev) check("read_data_hold", 64'(read_image_data), 64'(prev_data));
    if (read_image === 1'b1 && read_image_ready === 1'b1) begin
      n_rd++;
      if (exp_px_q.size() == 0) unexpected("read_pixel");
      else begin
        p = exp_px_q.pop_front();
        check("read_image_data", 64'(read_image_data), 64'(p));
      end
    end
    stall_prev = (read_image === 1'b1) && (read_image_ready !== 1'b1);
    prev_data  = read_image_data;
  end

  task automatic do_write(input logic [1:0] px[$], input int start, input int max_gap);
    int size = px.size();
    int got_cyc = -1;
    for (int j = 0; j * PPW < size; j++) begin
      logic [31:0] w = '0;
      for (int k = 0; k < PPW && j * PPW + k < size; k++) w |= 32'(px[j * PPW + k]) << slot_lsb(k);
      exp_wr_q.push_back('{addr: 13'(start + j), data: w});
    end
    image_size       = 23'(size);
    image_start_addr = 13'(start);
    write_image_en   = 1'b1;
    write_image      = 1'b1;  // strobe while still idle: must be ignored
    write_image_data = 2'($urandom);
    @(posedge clock); #1;
    foreach (px[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        write_image      = 1'b0;
        write_image_data = 2'($urandom);
        @(posedge clock); #1;
      end
      write_image      = 1'b1;
      write_image_data = px[i];
      @(posedge clock); #1;
    end
    write_image_data = 2'($urandom);  // strobe beyond image_size: must be ignored
    @(posedge clock); #1;
    write_image = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (write_image_done === 1'b1) begin
        got_cyc = cyc;
        break;
      end
    end
    check("write_done_seen", 64'(got_cyc >= 0), 64'(1));
    check("write_done_timing", 64'(got_cyc), 64'(last_wr_cyc + 1));
    check("writes_outstanding", 64'(exp_wr_q.size()), 64'(0));
    check("read_done_during_write", 64'(read_image_done), 64'(0));
    exp_wr_q.delete();
    @(posedge clock); #1;
    write_image_en = 1'b0;
    @(posedge clock); #1;
    check("write_done_release", 64'(write_image_done), 64'(0));
  endtask

  task automatic do_read(input int size, input int start, input int mode);
    int hold = 0;
    int n0 = n_rd;
    bit got = 0;
    for (int i = 0; i < size; i++) begin
      logic [31:0] w = mem[(start + i / PPW) % 8192];
      exp_px_q.push_back(2'(w >> slot_lsb(i % PPW)));
    end
    image_size       = 23'(size);
    image_start_addr = 13'(start);
    read_image_en    = 1'b1;
    read_image_ready = 1'b1;
    @(posedge clock);  // edge that leaves idle
    if (size > 0) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clock);
        check("first_read_latency", 64'(read_image), 64'(k == 3));
      end
    end
    for (int t = 0; t < 4000; t++) begin
      @(posedge clock); #1;
      if (read_image_done === 1'b1) begin
        got = 1;
        break;
      end
      if (mode == 1) begin
        if (n_rd - n0 == 5 && hold < 4) begin
          read_image_ready = 1'b0;
          hold++;
        end else read_image_ready = 1'b1;
      end else read_image_ready = ($urandom_range(0, 2) != 0);
    end
    check("read_done_seen", 64'(got), 64'(1));
    check("read_pixel_count", 64'(n_rd - n0), 64'(size));
    check("pixels_outstanding", 64'(exp_px_q.size()), 64'(0));
    check("write_done_during_read", 64'(write_image_done), 64'(0));
    exp_px_q.delete();
    read_image_en    = 1'b0;
    read_image_ready = 1'b0;
    @(posedge clock); #1;
    check("read_done_release", 64'(read_image_done), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0] q[$];
    bit got;
    reset = 1'b1;
    image_size = '0;
    image_start_addr = '0;
    write_image_en = 1'b0;
    write_image = 1'b0;
    write_image_data = '0;
    read_image_en = 1'b0;
    read_image_ready = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = $urandom;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sram_write", 64'(sram_write), 64'(0));
    check("rst_read_image", 64'(read_image), 64'(0));
    check("rst_write_done", 64'(write_image_done), 64'(0));
    check("rst_read_done", 64'(read_image_done), 64'(0));
    check("rst_read_data", 64'(read_image_data), 64'(0));
    check("rst_write_data", 64'(sram_write_data), 64'(0));
    check("rst_write_addr", 64'(sram_write_addr), 64'(0));
    check("rst_read_addr", 64'(sram_read_addr), 64'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // Ramp pattern, start 0, back-to-back strobes.
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(2'(i % 4));
    do_write(q, 0, 0);

    // Partial tail word at the top address, then a wrap across the address space.
    q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_write(q, 8191, 0);
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(2'($urandom));
    do_write(q, 8191, 0);

    repeat (4) begin
      q = {};
      for (int i = $urandom_range(1, 50); i > 0; i--) q.push_back(2'($urandom));
      do_write(q, int'($urandom_range(0, 8191)), 3);
    end

    // Constant-pattern read with a mid-word stall.
    for (int a = 0; a < 4; a++) mem[a] = 32'h9999_9999;
    do_read(64, 0, 1);
    do_read(40, 8190, 0);
    repeat (3) do_read(int'($urandom_range(1, 60)), int'($urandom_range(0, 8191)), 0);

    // Reset in the middle of a write.
    image_size = 23'd64;
    image_start_addr = 13'($urandom);
    write_image_en = 1'b1;
    write_image = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      write_image = 1'b1;
      write_image_data = 2'($urandom);
      @(posedge clock); #1;
    end
    reset = 1'b1;
    write_image = 1'b0;
    @(posedge clock); #1;
    check("midrst_sram_write", 64'(sram_write), 64'(0));
    check("midrst_read_image", 64'(read_image), 64'(0));
    check("midrst_write_done", 64'(write_image_done), 64'(0));
    check("midrst_read_done", 64'(read_image_done), 64'(0));
    check("midrst_read_data", 64'(read_image_data), 64'(0));
    check("midrst_write_data", 64'(sram_write_data), 64'(0));
    check("midrst_write_addr", 64'(sram_write_addr), 64'(0));
    check("midrst_read_addr", 64'(sram_read_addr), 64'(0));
    reset = 1'b0;
    write_image_en = 1'b0;
    @(posedge clock); #1;
    q = {};
    for (int i = 0; i < 21; i++) q.push_back(2'($urandom));
    do_write(q, int'($urandom_range(0, 8191)), 1);

    // Both enables, zero-size image: write wins, read follows once write_image_en drops.
    image_size = '0;
    write_image_en = 1'b1;
    read_image_en = 1'b1;
    @(posedge clock); #1;
    check("size0_write_done", 64'(write_image_done), 64'(1));
    check("size0_no_read_done", 64'(read_image_done), 64'(0));
    @(posedge clock); #1;
    check("size0_write_done_hold", 64'(write_image_done), 64'(1));
    write_image_en = 1'b0;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clock); #1;
      if (read_image_done === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("size0_read_serviced", 64'(got), 64'(1));
    check("size0_write_done_clear", 64'(write_image_done), 64'(0));
    read_image_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("size0_read_done_clear", 64'(read_image_done), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_image_ctrl.md
SRAM_IMAGE_CTRL -- requirements
Module: sram_image_ctrl

Interface
REQ-001 Parameter PIXEL_W, default 2, bits per pixel; SHALL divide WORD_W exactly.
REQ-002 Parameter WORD_W, default 32, SRAM data width; PPW = WORD_W/PIXEL_W pixels per word.
REQ-003 Parameter ADDR_W, default 13, SRAM address width.
REQ-004 Parameter SIZE_W, default 23, image size counter width.
REQ-005 Ports SHALL be:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
image_size  in  SIZE_W  pixels per image, sampled on leaving IDLE
image_start_addr  in  ADDR_W  first SRAM word, sampled on leaving IDLE
write_image_en  in  1  level request for a write transfer
write_image  in  1  pixel strobe
write_image_data  in  PIXEL_W  pixel value
write_image_done  out  1  write transfer complete
read_image_en  in  1  level request for a read transfer
read_image  out  1  pixel valid
read_image_ready  in  1  consumer accepts pixel
read_image_data  out  PIXEL_W  pixel value
read_image_done  out  1  read transfer complete
sram_clock  out  1  equal to clock
sram_write  out  1  one-cycle write strobe
sram_write_data  out  WORD_W  packed word
sram_write_addr  out  ADDR_W  write address
sram_read_data  in  WORD_W  read word, valid one cycle after address
sram_read_addr  out  ADDR_W  read address

Function
REQ-006 States: IDLE, WRITE, FLUSH, RD_ADDR, RD_WAIT, RD_OUT, DONE.
REQ-007 IDLE: write_image_en high -> WRITE; else read_image_en high -> RD_ADDR; both high -> write wins.
REQ-008 WRITE: each cycle with write_image high accepts one pixel into the packing register, slot k = pixel index mod PPW, LSB-first (slot 0 at bits PIXEL_W-1:0).
REQ-009 Strobes while not in WRITE, or after image_size pixels are accepted, SHALL be ignored.
REQ-010 The cycle after the PPW-th pixel of a word is accepted, sram_write SHALL be high for exactly one cycle with that word and current address; address then increments.
REQ-011 Accepting pixel number image_size with a partial word -> FLUSH; unused slots zero; word written next cycle.
REQ-012 write_image_done SHALL rise the cycle after the final sram_write and stay high in DONE.
REQ-013 RD_ADDR drives sram_read_addr; RD_WAIT; sram_read_data captured at end of RD_WAIT; RD_OUT presents slots in packing order.
REQ-014 First read_image high exactly 3 cycles after the edge that leaves IDLE; read_image_data stable while read_image high and read_image_ready low.
REQ-015 A pixel transfers when read_image and read_image_ready are both high; after slot PPW-1 -> RD_ADDR at next address; after pixel image_size -> DONE with read_image_done high; tail slots discarded.
REQ-016 Addresses SHALL wrap modulo 2^ADDR_W.
REQ-017 image_size 0: straight to DONE, done high next cycle, no SRAM access.
REQ-018 DONE: holds done until the initiating enable drops, then IDLE next cycle; deasserting an enable mid-transfer SHALL abort to IDLE without further SRAM access.

Reset
REQ-019 reset SHALL force IDLE, counters and packing register to 0, and sram_write, read_image, write_image_done, read_image_done, read_image_data, sram_write_data, sram_write_addr, sram_read_addr to 0, including mid-transfer.

Configuration
REQ-020 Macro SRAM_IMG_MSB_FIRST_EN defined: slot 0 occupies bits WORD_W-1:WORD_W-PIXEL_W for both pack and unpack; undefined: LSB-first per REQ-008.

Structure
REQ-021 Package sram_image_pkg SHALL hold the state enum typedef and PPW/slot-index width helper function.
REQ-022 One sub-module, pixel_word_packer (shift/pack register with slot counter), SHALL be shared by write and read paths instance-wise.

Verification
REQ-023 Defaults, size 64, start 0, pixels i mod 4 on consecutive cycles -> four writes of 0xE4E4E4E4 at addresses 0..3, then write_image_done.
REQ-024 Same with SRAM_IMG_MSB_FIRST_EN -> four writes of 0x1B1B1B1B.
REQ-025 Size 5, start 8191, pixels 0,1,2,3,0 -> one FLUSH write 0x000000E4 at 8191; size 20 -> writes at 8191 then 0.
REQ-026 Read size 64, sram_read_data 0x99999999, ready held low 4 cycles mid-word -> stream 1,2,1,2... with no loss or duplication, 64 pixels, addresses 0..3, read_image_done.
REQ-027 reset asserted after 10 pixels of a write -> all outputs 0 next cycle, no sram_write; subsequent transfer starts at slot 0.
REQ-028 Both enables raised together, size 0 -> write_image_done only, no SRAM access, read serviced after write_image_en drops.
